// File: rtl/cpu_sync_pkg.sv
// Shared types and encodings for the per-core sync hub: agent states,
// PIO command codes and PIO response codes.
package cpu_sync_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REL = 2'd1,
    RELEASED = 2'd2,
    HALTED   = 2'd3
  } agent_state_t;

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_SYNC = 2'd1;
  localparam logic [1:0] CMD_HALT = 2'd2;

  localparam logic [1:0] RSP_IDLE = 2'd0;
  localparam logic [1:0] RSP_WAIT = 2'd1;
  localparam logic [1:0] RSP_REL  = 2'd2;
  localparam logic [1:0] RSP_HALT = 2'd3;

  // Response code a core sees for a given agent state.
  function automatic logic [1:0] rsp_of(input agent_state_t st);
    logic [1:0] r;
    case (st)
      IDLE:     r = RSP_IDLE;
      WAIT_REL: r = RSP_WAIT;
      RELEASED: r = RSP_REL;
      HALTED:   r = RSP_HALT;
      default:  r = RSP_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_sync_agent.sv
// Single-core barrier agent: command FSM, continue edge detector,
// barrier wait timer and sticky timeout flag.
module cpu_sync_agent
  import cpu_sync_pkg::*;
#(
  parameter int TIMEOUT = 1000,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       soft_clr,
  input  logic [1:0] i_cmd,
  input  logic       i_continue,
  output logic [1:0] o_rsp,
  output logic       o_sync,
  output logic       o_halt,
  output logic       o_err,
  output logic       o_sync_nxt
);

  agent_state_t r_state;
  agent_state_t w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic          r_err;
  logic          w_err_nxt;
  logic          r_cont_s;
  logic          r_cont_q;
  logic          w_rise;
  logic [1:0]    w_cmd;

  // Reserved command code behaves like "none".
  assign w_cmd  = (i_cmd == 2'd3) ? CMD_NONE : i_cmd;
  // Edge taken on the sampled continue so a level held across WAIT_REL entry never releases.
  assign w_rise = r_cont_s & ~r_cont_q;

  // Next-state, timer and error computation.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_err_nxt   = r_err;
    if (soft_clr) begin
      w_state_nxt = IDLE;
      w_timer_nxt = '0;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmd == CMD_SYNC) begin
            w_state_nxt = WAIT_REL;
            w_timer_nxt = '0;
          end else if (w_cmd == CMD_HALT) begin
            w_state_nxt = HALTED;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        WAIT_REL: begin
          if (!w_rise && (r_timer == TW'(TIMEOUT - 1))) begin
            w_err_nxt = 1'b1;
          end else begin
            w_err_nxt = r_err;
          end
          if (w_cmd == CMD_HALT) begin
            w_state_nxt = HALTED;
          end else if (w_rise) begin
            w_state_nxt = RELEASED;
          end else if (r_timer != TW'(TIMEOUT)) begin
            w_timer_nxt = r_timer + TW'(1);
          end else begin
            w_timer_nxt = r_timer;
          end
        end
        RELEASED: begin
          if (w_cmd == CMD_HALT) begin
            w_state_nxt = HALTED;
          end else if (w_cmd == CMD_NONE) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = RELEASED;
          end
        end
        HALTED:  w_state_nxt = HALTED;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State, timer, error and continue-history registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_err    <= 1'b0;
      r_cont_s <= 1'b0;
      r_cont_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_err    <= w_err_nxt;
      r_cont_s <= i_continue;
      r_cont_q <= r_cont_s;
    end
  end

  assign o_rsp      = rsp_of(r_state);
  assign o_sync     = (r_state == WAIT_REL);
  assign o_halt     = (r_state == HALTED);
  assign o_err      = r_err;
  assign o_sync_nxt = (w_state_nxt == WAIT_REL);

endmodule

// File: rtl/cpu_sync_hub.sv
// Per-core front end of the run controller: one barrier agent per core
// plus a registered all-cores-synced flag aligned with sync_out.
module cpu_sync_hub
  import cpu_sync_pkg::*;
#(
  parameter int N_CPU   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               soft_clr,
  input  logic [2*N_CPU-1:0] cpu_cmd,
  output logic [2*N_CPU-1:0] cpu_rsp,
  input  logic [N_CPU-1:0]   continue_in,
  output logic [N_CPU-1:0]   sync_out,
  output logic [N_CPU-1:0]   halt_out,
  output logic               all_sync,
  output logic [N_CPU-1:0]   err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [N_CPU-1:0] w_sync_nxt;
  logic             r_all_sync;

  for (genvar g = 0; g < N_CPU; g++) begin : g_agent
    cpu_sync_agent #(
      .TIMEOUT(TIMEOUT),
      .TW     (TW)
    ) u_agent (
      .clk       (clk),
      .reset     (reset),
      .soft_clr  (soft_clr),
      .i_cmd     (cpu_cmd[2*g +: 2]),
      .i_continue(continue_in[g]),
      .o_rsp     (cpu_rsp[2*g +: 2]),
      .o_sync    (sync_out[g]),
      .o_halt    (halt_out[g]),
      .o_err     (err[g]),
      .o_sync_nxt(w_sync_nxt[g])
    );
  end

  // Built from next-state sync so it lands on the same edge as sync_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_all_sync <= 1'b0;
    end else begin
      r_all_sync <= &w_sync_nxt;
    end
  end

  assign all_sync = r_all_sync;

endmodule

// File: tb/tb_cpu_sync_hub.sv
// Scenario bench for cpu_sync_hub (N_CPU=4, TIMEOUT=16): per-cycle expected
// output vectors are queued as stimulus is applied and compared after the edge.
module tb_cpu_sync_hub;

  localparam logic [1:0] SI = 2'd0;
  localparam logic [1:0] SW = 2'd1;
  localparam logic [1:0] SR = 2'd2;
  localparam logic [1:0] SH = 2'd3;

  typedef struct {
    logic [7:0]  cmd;
    logic [3:0]  cont;
    logic        sclr;
    logic [20:0] exp;
  } step_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        soft_clr;
  logic [7:0]  cpu_cmd;
  logic [7:0]  cpu_rsp;
  logic [3:0]  continue_in;
  logic [3:0]  sync_out;
  logic [3:0]  halt_out;
  logic        all_sync;
  logic [3:0]  err;
  logic [20:0] obs;

  int checks   = 0;
  int failures = 0;
  logic [20:0] sb[$];

  always #5 clk = ~clk;

  cpu_sync_hub #(.N_CPU(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .soft_clr   (soft_clr),
    .cpu_cmd    (cpu_cmd),
    .cpu_rsp    (cpu_rsp),
    .continue_in(continue_in),
    .sync_out   (sync_out),
    .halt_out   (halt_out),
    .all_sync   (all_sync),
    .err        (err)
  );

  assign obs = {cpu_rsp, sync_out, halt_out, all_sync, err};

  // Expected output vector from the intended per-core states and err flags.
  function automatic step_t mk(input logic [7:0] c, input logic [3:0] k, input logic s,
                               input logic [1:0] s0, input logic [1:0] s1,
                               input logic [1:0] s2, input logic [1:0] s3,
                               input logic [3:0] e);
    step_t t;
    logic [3:0] sy;
    logic [3:0] hl;
    sy = {s3 == SW, s2 == SW, s1 == SW, s0 == SW};
    hl = {s3 == SH, s2 == SH, s1 == SH, s0 == SH};
    t.cmd  = c;
    t.cont = k;
    t.sclr = s;
    t.exp  = {s3, s2, s1, s0, sy, hl, &sy, e};
    return t;
  endfunction

  task automatic test_reset();
    step_t st[$];
    logic [20:0] got;
    reset = 1'b1; soft_clr = 1'b0; cpu_cmd = 8'h00; continue_in = 4'h0;
    @(posedge clk); #1;
    checks++;
    if (obs !== 21'h0) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", obs, 21'h0);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) st.push_back(mk(8'h01, 4'h0, 1'b0, SW, SI, SI, SI, 4'h0));
    foreach (st[i]) begin
      cpu_cmd = st[i].cmd; continue_in = st[i].cont; soft_clr = st[i].sclr;
      sb.push_back(st[i].exp);
      @(posedge clk); #1;
      checks++;
      got = sb.pop_front();
      if (obs !== got) begin
        failures++; $display("FAIL reset_wait step=%0d got=%h exp=%h", i, obs, got);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 21'h0) begin
      failures++; $display("FAIL reset_async got=%h exp=%h", obs, 21'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    st.delete();
    st.push_back(mk(8'h00, 4'h0, 1'b0, SI, SI, SI, SI, 4'h0));
    st.push_back(mk(8'h00, 4'h0, 1'b0, SI, SI, SI, SI, 4'h0));
    foreach (st[i]) begin
      cpu_cmd = st[i].cmd; continue_in = st[i].cont; soft_clr = st[i].sclr;
      sb.push_back(st[i].exp);
      @(posedge clk); #1;
      checks++;
      got = sb.pop_front();
      if (obs !== got) begin
        failures++; $display("FAIL reset_after step=%0d got=%h exp=%h", i, obs, got);
      end
    end
  endtask

  task automatic test_all_sync();
    step_t st[$];
    logic [20:0] got;
    st.push_back(mk(8'h01, 4'h0, 1'b0, SW, SI, SI, SI, 4'h0));
    st.push_back(mk(8'h05, 4'h0, 1'b0, SW, SW, SI, SI, 4'h0));
    st.push_back(mk(8'h15, 4'h0, 1'b0, SW, SW, SW, SI, 4'h0));
    st.push_back(mk(8'h55, 4'h0, 1'b0, SW, SW, SW, SW, 4'h0));
    st.push_back(mk(8'h55, 4'hF, 1'b0, SW, SW, SW, SW, 4'h0));
    st.push_back(mk(8'h55, 4'h0, 1'b0, SR, SR, SR, SR, 4'h0));
    st.push_back(mk(8'h55, 4'h0, 1'b0, SR, SR, SR, SR, 4'h0));
    st.push_back(mk(8'h00, 4'h0, 1'b0, SI, SI, SI, SI, 4'h0));
    st.push_back(mk(8'h55, 4'h0, 1'b0, SW, SW, SW, SW, 4'h0));
    st.push_back(mk(8'h55, 4'hF, 1'b0, SW, SW, SW, SW, 4'h0));
    st.push_back(mk(8'h55, 4'h0, 1'b0, SR, SR, SR, SR, 4'h0));
    st.push_back(mk(8'h00, 4'h0, 1'b0, SI, SI, SI, SI, 4'h0));
    foreach (st[i]) begin
      cpu_cmd = st[i].cmd; continue_in = st[i].cont; soft_clr = st[i].sclr;
      sb.push_back(st[i].exp);
      @(posedge clk); #1;
      checks++;
      got = sb.pop_front();
      if (obs !== got) begin
        failures++; $display("FAIL all_sync step=%0d got=%h exp=%h", i, obs, got);
      end
    end
  endtask

  task automatic test_stale_continue();
    step_t st[$];
    logic [20:0] got;
    st.push_back(mk(8'h00, 4'h2, 1'b0, SI, SI, SI, SI, 4'h0));
    st.push_back(mk(8'h00, 4'h2, 1'b0, SI, SI, SI, SI, 4'h0));
    for (int i = 0; i < 4; i++) st.push_back(mk(8'h04, 4'h2, 1'b0, SI, SW, SI, SI, 4'h0));
    st.push_back(mk(8'h04, 4'h0, 1'b0, SI, SW, SI, SI, 4'h0));
    st.push_back(mk(8'h04, 4'h2, 1'b0, SI, SW, SI, SI, 4'h0));
    st.push_back(mk(8'h04, 4'h2, 1'b0, SI, SR, SI, SI, 4'h0));
    st.push_back(mk(8'h00, 4'h0, 1'b0, SI, SI, SI, SI, 4'h0));
    st.push_back(mk(8'h00, 4'h0, 1'b0, SI, SI, SI, SI, 4'h0));
    foreach (st[i]) begin
      cpu_cmd = st[i].cmd; continue_in = st[i].cont; soft_clr = st[i].sclr;
      sb.push_back(st[i].exp);
      @(posedge clk); #1;
      checks++;
      got = sb.pop_front();
      if (obs !== got) begin
        failures++; $display("FAIL stale_continue step=%0d got=%h exp=%h", i, obs, got);
      end
    end
  endtask

  task automatic test_timeout();
    step_t st[$];
    logic [20:0] got;
    for (int i = 0; i < 16; i++) st.push_back(mk(8'h10, 4'h0, 1'b0, SI, SI, SW, SI, 4'h0));
    for (int i = 0; i < 4; i++)  st.push_back(mk(8'h10, 4'h0, 1'b0, SI, SI, SW, SI, 4'h4));
    st.push_back(mk(8'h10, 4'h4, 1'b0, SI, SI, SW, SI, 4'h4));
    st.push_back(mk(8'h10, 4'h0, 1'b0, SI, SI, SR, SI, 4'h4));
    st.push_back(mk(8'h00, 4'h0, 1'b0, SI, SI, SI, SI, 4'h4));
    st.push_back(mk(8'h00, 4'h0, 1'b1, SI, SI, SI, SI, 4'h0));
    st.push_back(mk(8'h00, 4'h0, 1'b0, SI, SI, SI, SI, 4'h0));
    foreach (st[i]) begin
      cpu_cmd = st[i].cmd; continue_in = st[i].cont; soft_clr = st[i].sclr;
      sb.push_back(st[i].exp);
      @(posedge clk); #1;
      checks++;
      got = sb.pop_front();
      if (obs !== got) begin
        failures++; $display("FAIL timeout step=%0d got=%h exp=%h", i, obs, got);
      end
    end
  endtask

  task automatic test_halt();
    step_t st[$];
    logic [20:0] got;
    st.push_back(mk(8'h40, 4'h0, 1'b0, SI, SI, SI, SW, 4'h0));
    st.push_back(mk(8'h80, 4'h0, 1'b0, SI, SI, SI, SH, 4'h0));
    st.push_back(mk(8'h00, 4'h0, 1'b0, SI, SI, SI, SH, 4'h0));
    st.push_back(mk(8'hC0, 4'h8, 1'b0, SI, SI, SI, SH, 4'h0));
    st.push_back(mk(8'h00, 4'h0, 1'b1, SI, SI, SI, SI, 4'h0));
    st.push_back(mk(8'hC0, 4'h0, 1'b0, SI, SI, SI, SI, 4'h0));
    st.push_back(mk(8'h00, 4'h0, 1'b0, SI, SI, SI, SI, 4'h0));
    foreach (st[i]) begin
      cpu_cmd = st[i].cmd; continue_in = st[i].cont; soft_clr = st[i].sclr;
      sb.push_back(st[i].exp);
      @(posedge clk); #1;
      checks++;
      got = sb.pop_front();
      if (obs !== got) begin
        failures++; $display("FAIL halt step=%0d got=%h exp=%h", i, obs, got);
      end
    end
  endtask

  task automatic test_soft_clr_priority();
    step_t st[$];
    logic [20:0] got;
    st.push_back(mk(8'h01, 4'h0, 1'b0, SW, SI, SI, SI, 4'h0));
    st.push_back(mk(8'h01, 4'h1, 1'b0, SW, SI, SI, SI, 4'h0));
    st.push_back(mk(8'h00, 4'h0, 1'b1, SI, SI, SI, SI, 4'h0));
    st.push_back(mk(8'h00, 4'h0, 1'b0, SI, SI, SI, SI, 4'h0));
    foreach (st[i]) begin
      cpu_cmd = st[i].cmd; continue_in = st[i].cont; soft_clr = st[i].sclr;
      sb.push_back(st[i].exp);
      @(posedge clk); #1;
      checks++;
      got = sb.pop_front();
      if (obs !== got) begin
        failures++; $display("FAIL soft_clr_priority step=%0d got=%h exp=%h", i, obs, got);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_sync();
    test_stale_continue();
    test_timeout();
    test_halt();
    test_soft_clr_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
